axis_stream_checker: RTL and testbench

//  AXI-Stream sink/scoreboard sitting directly downstream of the generator+FIFO stage; consumes its m00 stream.

---
 rtl/axis_stream_checker_pkg.sv | 17 +
 rtl/axis_stream_checker_if.sv | 25 ++
 rtl/axis_sat_counter.sv | 32 +++
 rtl/axis_stream_checker.sv | 172 +++++++++++++++++
 tb/tb_axis_stream_checker.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_stream_checker_pkg.sv
// Shared definitions for the AXI-Stream lab blocks.
//   axis_chk_state_e   : checker FSM encoding (IDLE/RUN/DONE)
//   AXIS_DATA_SIZE     : default TDATA width used by the stream interface
//   AXIS_STRB_ALL_ONES : wide all-ones strobe; users slice their own width
package axis_stream_checker_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } axis_chk_state_e;

   localparam int AXIS_DATA_SIZE = 32;

   localparam logic [127:0] AXIS_STRB_ALL_ONES = '1;

endpackage

// File: rtl/axis_stream_checker_if.sv
// AXI-Stream handshake bundle.
//   tdata/tstrb/tvalid/tlast : driven by the master
//   tready                   : driven by the slave
// modports: master (stream source), slave (stream sink)
interface axis_stream_checker_if
   import axis_stream_checker_pkg::*;
#(
   parameter int DATA_SIZE = AXIS_DATA_SIZE
);
   logic [DATA_SIZE-1:0]   tdata;
   logic [DATA_SIZE/8-1:0] tstrb;
   logic                   tvalid;
   logic                   tlast;
   logic                   tready;

   modport master (
      output tdata, tstrb, tvalid, tlast,
      input  tready
   );

   modport slave (
      input  tdata, tstrb, tvalid, tlast,
      output tready
   );
endinterface

// File: rtl/axis_sat_counter.sv
// Saturating up-counter used for the checker status counters.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : count one event this cycle
//   count      : registered count, sticks at all-ones
module axis_sat_counter #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 inc,
   output logic [CNT_WIDTH-1:0] count
);
   logic [CNT_WIDTH-1:0] count_q;
   logic [CNT_WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != '1)) begin
         count_d = count_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
endmodule

// File: rtl/axis_stream_checker.sv
// AXI-Stream sink that checks an incrementing data pattern and fixed-length
// packet framing, with optional periodic backpressure.
//   s00_axis_aclk / s00_axis_aresetn : clock, asynchronous active-low reset
//   s00_axis_enable                  : 1 = accept traffic
//   s00_axis (slave modport)         : tdata/tstrb/tvalid/tlast in, tready out (registered)
//   beat_count / pkt_count           : accepted beats / accepted TLAST beats
//   data_err_count / last_err_count  : TDATA-or-TSTRB mismatches / TLAST mismatches
//   err_sticky / done                : any error since reset / NUM_PKTS packets seen
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | not enabled; tready low, counters and expected data hold
// ST_RUN  | accepting and checking beats, with optional periodic stall
// ST_DONE | NUM_PKTS packets received; tready low until reset
module axis_stream_checker
   import axis_stream_checker_pkg::*;
#(
   parameter int DATA_SIZE    = 32,
   parameter int PKT_LEN      = 16,
   parameter int NUM_PKTS     = 0,
   parameter int STALL_PERIOD = 0,
   parameter int CNT_WIDTH    = 32
) (
   input  logic                 s00_axis_aclk,
   input  logic                 s00_axis_aresetn,
   input  logic                 s00_axis_enable,
   axis_stream_checker_if.slave s00_axis,
   output logic [CNT_WIDTH-1:0] beat_count,
   output logic [CNT_WIDTH-1:0] pkt_count,
   output logic [CNT_WIDTH-1:0] data_err_count,
   output logic [CNT_WIDTH-1:0] last_err_count,
   output logic                 err_sticky,
   output logic                 done
);
   localparam int STRB_W  = DATA_SIZE / 8;
   localparam int IDX_W   = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam int STALL_W = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;

   localparam logic [STRB_W-1:0]  STRB_FULL    = AXIS_STRB_ALL_ONES[STRB_W-1:0];
   localparam logic [IDX_W-1:0]   IDX_LAST     = IDX_W'(PKT_LEN - 1);
   localparam logic [STALL_W-1:0] STALL_RELOAD = STALL_W'((STALL_PERIOD > 0) ? STALL_PERIOD - 1 : 0);
   localparam logic [CNT_WIDTH:0] PKT_TARGET   = (CNT_WIDTH+1)'(NUM_PKTS);
   localparam logic [CNT_WIDTH:0] PKT_ONE      = (CNT_WIDTH+1)'(1);

   axis_chk_state_e      state_q,     state_d;
   logic [STALL_W-1:0]   stall_cnt_q, stall_cnt_d;
   logic [DATA_SIZE-1:0] exp_data_q,  exp_data_d;
   logic [IDX_W-1:0]     beat_idx_q,  beat_idx_d;
   logic                 tready_q,    tready_d;
   logic                 err_sticky_q, err_sticky_d;
   logic                 done_q,      done_d;

   logic accept;
   logic at_last;
   logic data_err;
   logic last_err;
   logic pkt_hit;
   logic final_pkt;

   assign accept    = s00_axis.tvalid && tready_q;
   assign at_last   = (beat_idx_q == IDX_LAST);
   assign data_err  = (s00_axis.tdata != exp_data_q) || (s00_axis.tstrb != STRB_FULL);
   assign last_err  = (s00_axis.tlast != at_last);
   // pkt_count still holds the pre-accept value here, so +1 is this packet
   assign pkt_hit   = (({1'b0, pkt_count} + PKT_ONE) == PKT_TARGET);
   assign final_pkt = accept && s00_axis.tlast && (NUM_PKTS != 0) && pkt_hit;

   always_comb begin
      state_d      = state_q;
      stall_cnt_d  = stall_cnt_q;
      exp_data_d   = exp_data_q;
      beat_idx_d   = beat_idx_q;
      err_sticky_d = err_sticky_q;
      done_d       = done_q;

      case (state_q)
         ST_IDLE: begin
            if (s00_axis_enable) begin
               state_d     = ST_RUN;
               stall_cnt_d = STALL_RELOAD;
            end
         end
         ST_RUN: begin
            if (final_pkt) begin
               state_d = ST_DONE;
            end else if (!s00_axis_enable) begin
               state_d = ST_IDLE;
            end else begin
               stall_cnt_d = (stall_cnt_q == '0) ? STALL_RELOAD : stall_cnt_q - STALL_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Resync both data and framing to whatever the sender actually did
      if (accept) begin
         exp_data_d = s00_axis.tdata + DATA_SIZE'(1);
         if (s00_axis.tlast || at_last) begin
            beat_idx_d = '0;
         end else begin
            beat_idx_d = beat_idx_q + IDX_W'(1);
         end
         if (data_err || last_err) begin
            err_sticky_d = 1'b1;
         end
      end

      if (final_pkt) begin
         done_d = 1'b1;
      end

      // Down-counter terminal count marks the single stall cycle per period
      tready_d = (state_d == ST_RUN) && !((STALL_PERIOD != 0) && (stall_cnt_d == '0));
   end

   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) begin
         state_q      <= ST_IDLE;
         stall_cnt_q  <= '0;
         exp_data_q   <= '0;
         beat_idx_q   <= '0;
         tready_q     <= 1'b0;
         err_sticky_q <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         stall_cnt_q  <= stall_cnt_d;
         exp_data_q   <= exp_data_d;
         beat_idx_q   <= beat_idx_d;
         tready_q     <= tready_d;
         err_sticky_q <= err_sticky_d;
         done_q       <= done_d;
      end
   end

   axis_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_beat_cnt (
      .clk   (s00_axis_aclk),
      .rst_n (s00_axis_aresetn),
      .inc   (accept),
      .count (beat_count)
   );

   axis_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_pkt_cnt (
      .clk   (s00_axis_aclk),
      .rst_n (s00_axis_aresetn),
      .inc   (accept && s00_axis.tlast),
      .count (pkt_count)
   );

   axis_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_data_err_cnt (
      .clk   (s00_axis_aclk),
      .rst_n (s00_axis_aresetn),
      .inc   (accept && data_err),
      .count (data_err_count)
   );

   axis_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_last_err_cnt (
      .clk   (s00_axis_aclk),
      .rst_n (s00_axis_aresetn),
      .inc   (accept && last_err),
      .count (last_err_count)
   );

   assign s00_axis.tready = tready_q;
   assign err_sticky      = err_sticky_q;
   assign done            = done_q;
endmodule

// File: tb/tb_axis_stream_checker.sv
// Bench for axis_stream_checker. Two instances:
//   dut 0 : PKT_LEN 16, free-running, no stall
//   dut 1 : PKT_LEN 16, NUM_PKTS 2, STALL_PERIOD 4
// The driver pushes the expected status for each beat into a per-dut queue;
// a negedge monitor pops and compares one cycle after each accept.
module tb_axis_stream_checker;

   typedef struct packed {
      logic [31:0] beat;
      logic [31:0] pkt;
      logic [31:0] derr;
      logic [31:0] lerr;
      logic        sticky;
      logic        done;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic        en       [2];
   logic [31:0] tdata_r  [2];
   logic [3:0]  tstrb_r  [2];
   logic        tvalid_r [2];
   logic        tlast_r  [2];
   logic        tready_w [2];
   logic [31:0] beat_w   [2];
   logic [31:0] pkt_w    [2];
   logic [31:0] derr_w   [2];
   logic [31:0] lerr_w   [2];
   logic        sticky_w [2];
   logic        done_w   [2];

   axis_stream_checker_if #(.DATA_SIZE(32)) if_a ();
   axis_stream_checker_if #(.DATA_SIZE(32)) if_b ();

   assign if_a.tdata  = tdata_r[0];
   assign if_a.tstrb  = tstrb_r[0];
   assign if_a.tvalid = tvalid_r[0];
   assign if_a.tlast  = tlast_r[0];
   assign tready_w[0] = if_a.tready;
   assign if_b.tdata  = tdata_r[1];
   assign if_b.tstrb  = tstrb_r[1];
   assign if_b.tvalid = tvalid_r[1];
   assign if_b.tlast  = tlast_r[1];
   assign tready_w[1] = if_b.tready;

   axis_stream_checker #(
      .DATA_SIZE(32), .PKT_LEN(16), .NUM_PKTS(0), .STALL_PERIOD(0), .CNT_WIDTH(32)
   ) dut_a (
      .s00_axis_aclk    (clk),
      .s00_axis_aresetn (rst_n),
      .s00_axis_enable  (en[0]),
      .s00_axis         (if_a),
      .beat_count       (beat_w[0]),
      .pkt_count        (pkt_w[0]),
      .data_err_count   (derr_w[0]),
      .last_err_count   (lerr_w[0]),
      .err_sticky       (sticky_w[0]),
      .done             (done_w[0])
   );

   axis_stream_checker #(
      .DATA_SIZE(32), .PKT_LEN(16), .NUM_PKTS(2), .STALL_PERIOD(4), .CNT_WIDTH(32)
   ) dut_b (
      .s00_axis_aclk    (clk),
      .s00_axis_aresetn (rst_n),
      .s00_axis_enable  (en[1]),
      .s00_axis         (if_b),
      .beat_count       (beat_w[1]),
      .pkt_count        (pkt_w[1]),
      .data_err_count   (derr_w[1]),
      .last_err_count   (lerr_w[1]),
      .err_sticky       (sticky_w[1]),
      .done             (done_w[1])
   );

   int   n_vec = 0;
   int   n_err = 0;
   exp_t q0 [$];
   exp_t q1 [$];
   int   m_beat [2];
   int   m_pkt  [2];
   int   m_derr [2];
   int   m_lerr [2];
   bit   m_sticky [2];
   bit   pend [2];

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_entry(input int s, input exp_t e);
      cmp($sformatf("dut%0d beat_count", s), beat_w[s], e.beat);
      cmp($sformatf("dut%0d pkt_count", s), pkt_w[s], e.pkt);
      cmp($sformatf("dut%0d data_err_count", s), derr_w[s], e.derr);
      cmp($sformatf("dut%0d last_err_count", s), lerr_w[s], e.lerr);
      cmp($sformatf("dut%0d err_sticky", s), 32'(sticky_w[s]), 32'(e.sticky));
      cmp($sformatf("dut%0d done", s), 32'(done_w[s]), 32'(e.done));
   endtask

   task automatic check_idle(input int s);
      cmp($sformatf("dut%0d reset tready", s), 32'(tready_w[s]), 32'd0);
      cmp($sformatf("dut%0d reset beat_count", s), beat_w[s], 32'd0);
      cmp($sformatf("dut%0d reset pkt_count", s), pkt_w[s], 32'd0);
      cmp($sformatf("dut%0d reset data_err_count", s), derr_w[s], 32'd0);
      cmp($sformatf("dut%0d reset last_err_count", s), lerr_w[s], 32'd0);
      cmp($sformatf("dut%0d reset err_sticky", s), 32'(sticky_w[s]), 32'd0);
      cmp($sformatf("dut%0d reset done", s), 32'(done_w[s]), 32'd0);
   endtask

   task automatic summary();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
   endtask

   // Monitor: a beat seen valid&ready at a negedge is accepted on the next
   // posedge, so its status is checked at the negedge after that.
   always @(negedge clk) begin : monitor
      exp_t e;
      for (int s = 0; s < 2; s++) begin
         if (pend[s]) begin
            n_vec++;
            if ((s == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
               n_err++;
               $display("FAIL dut%0d accept: got an accepted beat, expected none queued", s);
            end else begin
               n_vec--;
               e = (s == 0) ? q0.pop_front() : q1.pop_front();
               check_entry(s, e);
            end
         end
         pend[s] = rst_n && tvalid_r[s] && tready_w[s];
      end
   end

   task automatic send(input int s, input logic [31:0] d, input logic [3:0] st,
                       input logic l, input bit de, input bit le);
      exp_t e;
      int   waitc;
      m_beat[s]++;
      if (l)  m_pkt[s]++;
      if (de) m_derr[s]++;
      if (le) m_lerr[s]++;
      if (de || le) m_sticky[s] = 1'b1;
      e.beat   = 32'(m_beat[s]);
      e.pkt    = 32'(m_pkt[s]);
      e.derr   = 32'(m_derr[s]);
      e.lerr   = 32'(m_lerr[s]);
      e.sticky = m_sticky[s];
      e.done   = (s == 1) && (m_pkt[1] == 2);
      if (s == 0) q0.push_back(e); else q1.push_back(e);
      tdata_r[s]  = d;
      tstrb_r[s]  = st;
      tlast_r[s]  = l;
      tvalid_r[s] = 1'b1;
      waitc = 0;
      do begin
         @(negedge clk);
         waitc++;
      end while (!tready_w[s] && waitc < 20);
      if (!tready_w[s]) begin
         n_err++;
         $display("FAIL dut%0d accept timeout: tready still 0 after %0d cycles, expected 1", s, waitc);
         summary();
         $fatal(1, "stopping on accept timeout");
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      for (int s = 0; s < 2; s++) begin
         en[s] = 1'b0;
         tvalid_r[s] = 1'b0;
         tlast_r[s] = 1'b0;
         m_beat[s] = 0;
         m_pkt[s] = 0;
         m_derr[s] = 0;
         m_lerr[s] = 0;
         m_sticky[s] = 1'b0;
      end
      rst_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin : watchdog
      #300000;
      n_err++;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      summary();
      $fatal(1, "stopping on watchdog");
   end

   initial begin : main
      logic [31:0] nd;
      logic [31:0] d;
      int hi;
      int w;
      for (int s = 0; s < 2; s++) begin
         en[s] = 1'b0;
         tdata_r[s] = '0;
         tstrb_r[s] = 4'hF;
         tvalid_r[s] = 1'b0;
         tlast_r[s] = 1'b0;
         pend[s] = 1'b0;
      end
      #2 rst_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check_idle(0);
      check_idle(1);
      do_reset();

      // clean stream 0..31, two packets
      en[0] = 1'b1;
      @(posedge clk);
      #1;
      cmp("dut0 tready after enable", 32'(tready_w[0]), 32'd1);
      for (int i = 0; i < 32; i++) begin
         send(0, 32'(i), 4'hF, (i % 16) == 15, 1'b0, 1'b0);
      end
      tvalid_r[0] = 1'b0;
      @(negedge clk);
      cmp("dut0 clean beats", beat_w[0], 32'd32);
      cmp("dut0 clean pkts", pkt_w[0], 32'd2);

      // data error on beat 5 then resync; early tlast then clean packet
      do_reset();
      en[0] = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 16; i++) begin
         d = (i < 5) ? 32'(i) : 32'hDEAD + 32'(i - 5);
         send(0, d, 4'hF, i == 15, i == 5, 1'b0);
      end
      nd = 32'hDEB8;
      for (int j = 0; j < 11; j++) begin
         send(0, nd + 32'(j), 4'hF, j == 10, 1'b0, j == 10);
      end
      nd = nd + 32'd11;
      for (int j = 0; j < 16; j++) begin
         send(0, nd + 32'(j), 4'hF, j == 15, 1'b0, 1'b0);
      end
      nd = nd + 32'd16;

      // enable drops while a beat is offered: beat still counted
      en[0] = 1'b0;
      send(0, nd, 4'hF, 1'b0, 1'b0, 1'b0);
      cmp("dut0 tready after enable drop", 32'(tready_w[0]), 32'd0);
      tvalid_r[0] = 1'b0;
      @(negedge clk);
      cmp("dut0 beats after enable drop", beat_w[0], 32'd44);

      // wrap through all-ones, bad strobe, then reset mid-packet
      do_reset();
      en[0] = 1'b1;
      @(posedge clk);
      #1;
      send(0, 32'hFFFF_FFFE, 4'hF, 1'b0, 1'b1, 1'b0);
      send(0, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b0, 1'b0);
      send(0, 32'h0000_0000, 4'hF, 1'b0, 1'b0, 1'b0);
      send(0, 32'h0000_0001, 4'hF, 1'b0, 1'b0, 1'b0);
      send(0, 32'h0000_0002, 4'h7, 1'b0, 1'b1, 1'b0);
      send(0, 32'h0000_0003, 4'hF, 1'b0, 1'b0, 1'b0);
      tvalid_r[0] = 1'b0;
      @(negedge clk);
      cmp("dut0 data errs before reset", derr_w[0], 32'd2);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_idle(0);
      do_reset();

      // periodic stall and NUM_PKTS completion
      en[1] = 1'b1;
      hi = 0;
      fork
         begin
            for (int i = 0; i < 32; i++) begin
               send(1, 32'(i), 4'hF, (i % 16) == 15, 1'b0, 1'b0);
            end
         end
         begin
            w = 0;
            do begin
               @(negedge clk);
               w++;
            end while (!tready_w[1] && w < 10);
            for (int k = 0; k < 16; k++) begin
               if (k > 0) @(negedge clk);
               if (tready_w[1]) hi++;
               cmp($sformatf("dut1 tready run cycle %0d", k), 32'(tready_w[1]), 32'((k % 4) != 3));
            end
            cmp("dut1 ready cycles in 16", 32'(hi), 32'd12);
         end
      join
      cmp("dut1 tready after final tlast", 32'(tready_w[1]), 32'd0);
      cmp("dut1 done after final tlast", 32'(done_w[1]), 32'd1);
      tdata_r[1]  = 32'd32;
      tlast_r[1]  = 1'b1;
      tvalid_r[1] = 1'b1;
      repeat (5) @(negedge clk);
      cmp("dut1 frozen beats", beat_w[1], 32'd32);
      cmp("dut1 frozen pkts", pkt_w[1], 32'd2);
      cmp("dut1 frozen data errs", derr_w[1], 32'd0);
      cmp("dut1 frozen tready", 32'(tready_w[1]), 32'd0);
      cmp("dut1 frozen done", 32'(done_w[1]), 32'd1);
      tvalid_r[1] = 1'b0;
      cmp("dut0 leftover expectations", 32'(q0.size()), 32'd0);
      cmp("dut1 leftover expectations", 32'(q1.size()), 32'd0);

      summary();
      $finish;
   end
endmodule
